y_stream_packer: RTL and testbench
==================================

# y_stream_packer

Downstream consumer of the per-cycle 1-bit result stream (`y`) produced by the `Foo` datapath. It packs accepted bits LSB-first into DATA_W-bit words and buffers them in a DEPTH-entry FIFO, presenting them on a valid/ready read port. A flush request pushes out a partially filled word, zero-padded in its upper bits. It decouples the bit-rate producer from a word-oriented sink such as a register-file or bus writer.

## Interface
- DATA_W, 8, packed word width; ≥2.
- DEPTH, 16, FIFO entries; power of two, ≥2.
- clock  input  1  the single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clock.
- in_valid  input  1  `in_bit` is valid this cycle.
- in_bit  input  1  data bit (driven from `Foo.y`).
- in_ready  output  1  the block accepts `in_bit` this cycle when high.
- flush  input  1  request to push the current partial word.
- out_valid  output  1  `out_data` holds the FIFO head.
- out_ready  input  1  the sink takes the head this cycle.
- out_data  output  DATA_W  FIFO head word; 0 when `out_valid` is 0.
- level  output  $clog2(DEPTH)+1  number of words held in the FIFO, 0..DEPTH.

## Operation
- Accept: `acc = in_valid & in_ready`. An accepted bit is written to position `bit_cnt` of the assembly register, then `bit_cnt` increments.
- Word complete: when the accepted bit has `bit_cnt == DATA_W-1`, the full word is pushed to the FIFO and both `bit_cnt` and the assembly register clear.
- `in_ready = !(full && bit_cnt == DATA_W-1)`. Partial bits are accepted even when the FIFO is full. Only the bit that would complete a word is stalled.
- Flush: takes effect when `flush=1`, `bit_cnt>0` (counting any bit accepted this cycle), and the FIFO is not full.
  - The word is pushed with unfilled upper bits = 0, and `bit_cnt` clears.
  - With `bit_cnt==0`, flush has no effect.
  - With the FIFO full, flush is ignored that cycle; the requester holds `flush` high until it takes effect.
- Flush plus accept in the same cycle: the accepted bit is included in the flushed word. If that bit completes the word, exactly one push occurs.
- FIFO:
  - Show-ahead: `out_data = mem[rd_ptr]`.
  - Pop on `out_valid & out_ready`.
  - Push is allowed only when `!full`. There is no pass-through while full, even with a simultaneous pop.
  - Simultaneous push and pop when non-empty and non-full leaves `level` unchanged.
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
  - `full = (level == DEPTH)`; `out_valid = (level != 0)`.
- Pop while empty cannot occur, because `out_valid` gates it.
- Reset (reset==0 at a rising edge):
  - Clears `bit_cnt`, the assembly register, the pointers and `level`.
  - Outputs after that edge: `out_valid=0`, `out_data=0`, `level=0`, `in_ready=1`.
  - FIFO memory contents are not cleared.
  - A reset mid-word or mid-flush discards all held data. It has priority over every other input.

## Timing
- The word-completing bit accepted at edge N makes `out_valid=1` and `level` increment in the cycle after edge N (latency 1).
- A flush taking effect at edge N behaves the same way.
- A pop at edge N presents the next head, or `out_valid=0`, in the cycle after edge N.
- `in_ready` depends only on registered state. There is no combinational path from `out_ready` to `in_ready`.
- `out_valid`, `out_data` and `level` come from registers and memory only; none depends on the inputs of the same cycle.

## Test plan
- Reset then pack: reset=0 for 2 cycles, then feed bits 1,0,1,0,0,0,0,1 with in_valid=1 and out_ready=0.
  - Required: out_data=8'h85 and level=1 one cycle after the 8th bit; out_valid is 0 before that cycle.
- Flush partial: feed bits 1,1,1, then flush=1 alone.
  - Required: out_data=8'h07 and level=1 next cycle.
  - A second flush with bit_cnt=0 leaves level at 1.
- Full backpressure: with out_ready=0, stream 16×8+7 bits.
  - Required: level=16 and in_ready=0.
  - Raise out_ready for 1 cycle: level=15, then in_ready=1 and the pending bit is accepted.
- Flush while full: level=16 with 3 bits held, flush held high.
  - Required: no push while full.
  - After one pop, the padded word is pushed and level returns to 16.
- Simultaneous push and pop: level=4 with out_ready=1, completing a word on the same edge as a pop.
  - Required: level stays 4, and words emerge in order.
  - Run across pointer wrap (more than 16 pushes).
- Reset mid-operation: level=5 and bit_cnt=3, then reset=0 for one edge.
  - Required: out_valid=0, level=0, in_ready=1.
  - The next 8 bits form a fresh word with no residual bits.

Source files
------------

// File: rtl/y_stream_packer.sv
// y_stream_packer: packs an accepted 1-bit stream LSB-first into DATA_W-bit
// words and queues them in a DEPTH-entry show-ahead FIFO with a valid/ready
// read port. A flush pushes a partially filled word, zero-padded above.
module y_stream_packer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_bit,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [LW-1:0]     level_q;

  logic              full_c;
  logic              last_bit_c;
  logic              acc_c;
  logic              word_done_c;
  logic              flush_go_c;
  logic              push_c;
  logic              pop_c;
  logic [DATA_W-1:0] asm_next_c;

  // Status and handshake decode; in_ready looks only at registered state.
  always_comb begin
    full_c      = (level_q == LW'(DEPTH));
    last_bit_c  = (bit_cnt == CW'(DATA_W - 1));
    in_ready    = !(full_c && last_bit_c);
    acc_c       = in_valid && in_ready;
    out_valid   = (level_q != '0);
    out_data    = out_valid ? mem[rd_ptr] : '0;
    level       = level_q;
    pop_c       = out_valid && out_ready;
    asm_next_c  = asm_q;
    if (acc_c) begin
      asm_next_c[bit_cnt] = in_bit;
    end
    // A completing bit can only be accepted when not full, so push never overflows.
    word_done_c = acc_c && last_bit_c;
    flush_go_c  = flush && ((bit_cnt != '0) || acc_c) && !full_c;
    push_c      = word_done_c || flush_go_c;
  end

  // Bit assembly: the in-flight word is pushed whole, including this cycle's bit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bit_cnt <= '0;
      asm_q   <= '0;
    end else if (push_c) begin
      bit_cnt <= '0;
      asm_q   <= '0;
    end else begin
      asm_q <= asm_next_c;
      if (acc_c) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_c && !pop_c) begin
        level_q <= level_q + LW'(1);
      end else if (pop_c && !push_c) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  // FIFO storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clock) begin
    if (reset && push_c) begin
      mem[wr_ptr] <= asm_next_c;
    end
  end

endmodule

// File: tb/tb_y_stream_packer.sv
// Self-checking bench for y_stream_packer: a bit-level reference model feeds a
// scoreboard of expected words, compared whenever the FIFO head is observed.
module tb_y_stream_packer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_word;
  int         m_cnt;

  y_stream_packer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  always #5 clock = ~clock;

  // One clock of stimulus; model predicts handshakes, scoreboard checks the head.
  task automatic cycle(input logic v, input logic b, input logic f, input logic r);
    logic       exp_rdy;
    logic       acc;
    logic       pop;
    logic       push;
    logic [7:0] w;
    logic [7:0] dummy;
    in_valid = v; in_bit = b; flush = f; out_ready = r;
    #1;
    exp_rdy = !(exp_q.size() == DEPTH && m_cnt == DATA_W - 1);
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++; $display("FAIL in_ready got %b exp %b", in_ready, exp_rdy);
    end
    checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      errors++; $display("FAIL out_valid got %b exp %b", out_valid, exp_q.size() != 0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      if (out_data !== exp_q[0]) begin
        errors++; $display("FAIL head_word got %h exp %h", out_data, exp_q[0]);
      end
    end else if (out_data !== 8'h00) begin
      errors++; $display("FAIL idle_data got %h exp 00", out_data);
    end
    pop  = r && (exp_q.size() != 0);
    acc  = v && exp_rdy;
    w    = m_word;
    if (acc) w[m_cnt] = b;
    push = (acc && m_cnt == DATA_W - 1) ||
           (f && (m_cnt != 0 || acc) && exp_q.size() != DEPTH);
    @(posedge clock);
    if (pop) dummy = exp_q.pop_front();
    if (push) begin
      exp_q.push_back(w); m_word = '0; m_cnt = 0;
    end else begin
      m_word = w;
      if (acc) m_cnt++;
    end
    #1;
    checks++;
    if (level !== 5'(exp_q.size())) begin
      errors++; $display("FAIL level got %0d exp %0d", level, exp_q.size());
    end
  endtask

  task automatic apply_reset(input int n);
    in_valid = 0; in_bit = 0; flush = 0; out_ready = 0; reset = 0;
    repeat (n) @(posedge clock);
    #1;
    reset = 1;
    exp_q.delete(); m_word = '0; m_cnt = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle(0, 0, 0, 1);
    checks++;
    if (level !== 5'd0) begin
      errors++; $display("FAIL drain_level got %0d exp 0", level);
    end
  endtask

  task automatic test_reset();
    apply_reset(2);
    checks++;
    if (out_valid !== 1'b0 || level !== 5'd0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got v=%b l=%0d r=%b d=%h exp v=0 l=0 r=1 d=00",
               out_valid, level, in_ready, out_data);
    end
  endtask

  task automatic test_pack();
    logic [7:0] bits;
    bits = 8'b1000_0101;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL pack_early_valid got %b exp 0", out_valid);
      end
      cycle(1, bits[i], 0, 0);
    end
    in_valid = 0;
    checks++;
    if (out_data !== 8'h85 || level !== 5'd1) begin
      errors++; $display("FAIL pack_word got %h/%0d exp 85/1", out_data, level);
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
    cycle(0, 0, 1, 0);
    checks++;
    if (out_data !== 8'h07 || level !== 5'd1) begin
      errors++; $display("FAIL flush_partial got %h/%0d exp 07/1", out_data, level);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (level !== 5'd1) begin
      errors++; $display("FAIL flush_empty got %0d exp 1", level);
    end
    // Flush together with the completing bit: exactly one push.
    for (int i = 0; i < 7; i++) cycle(1, 1'($urandom), 0, 0);
    cycle(1, 1, 1, 0);
    checks++;
    if (level !== 5'd2) begin
      errors++; $display("FAIL flush_with_last got %0d exp 2", level);
    end
    drain();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH * 8 + 7; i++) cycle(1, 1'($urandom), 0, 0);
    checks++;
    if (level !== 5'd16 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_stall got %0d/%b exp 16/0", level, in_ready);
    end
    cycle(1, 1, 0, 1);
    checks++;
    if (level !== 5'd15 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_pop got %0d/%b exp 15/1", level, in_ready);
    end
    cycle(1, 1, 0, 0);
    checks++;
    if (level !== 5'd16) begin
      errors++; $display("FAIL full_resume got %0d exp 16", level);
    end
  endtask

  task automatic test_flush_full();
    for (int i = 0; i < 3; i++) cycle(1, 1'($urandom), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
    checks++;
    if (level !== 5'd16) begin
      errors++; $display("FAIL flush_full_blocked got %0d exp 16", level);
    end
    cycle(0, 0, 1, 1);
    checks++;
    if (level !== 5'd15) begin
      errors++; $display("FAIL flush_full_pop got %0d exp 15", level);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (level !== 5'd16) begin
      errors++; $display("FAIL flush_full_push got %0d exp 16", level);
    end
    flush = 0;
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) cycle(1, 1'($urandom), 0, 0);
    for (int w = 0; w < 20; w++) begin
      for (int i = 0; i < 8; i++) cycle(1, 1'($urandom), 0, 1'(i == 7));
      checks++;
      if (level !== 5'd4) begin
        errors++; $display("FAIL b2b_level got %0d exp 4", level);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 43; i++) cycle(1, 1'($urandom), 0, 0);
    checks++;
    if (level !== 5'd5) begin
      errors++; $display("FAIL mid_setup got %0d exp 5", level);
    end
    apply_reset(1);
    checks++;
    if (out_valid !== 1'b0 || level !== 5'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got v=%b l=%0d r=%b exp v=0 l=0 r=1", out_valid, level, in_ready);
    end
    begin
      logic [7:0] bits;
      bits = 8'h5A;
      for (int i = 0; i < 8; i++) cycle(1, bits[i], 0, 0);
    end
    in_valid = 0;
    checks++;
    if (out_data !== 8'h5A || level !== 5'd1) begin
      errors++; $display("FAIL mid_fresh got %h/%0d exp 5a/1", out_data, level);
    end
    drain();
  endtask

  initial begin
    reset = 1; in_valid = 0; in_bit = 0; flush = 0; out_ready = 0;
    m_word = '0; m_cnt = 0;
    @(posedge clock); #1;
    test_reset();
    test_pack();
    test_flush();
    test_full();
    test_flush_full();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
